// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional first-word-fall-through read.
module sync_fifo_flags #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // All flags decode from registered state only; enables never reach them combinationally.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    always_comb begin
        wr_acc      = wr_en & ~full;
        rd_acc      = rd_en & ~empty;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        if (wr_acc) wptr_d = wptr_q + AW'(1);
        if (rd_acc) begin
            rptr_d  = rptr_q + AW'(1);
            rdata_d = mem_q[rptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A fresh error event in the same cycle as clr_err keeps the flag set.
        overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full);
        underflow_d = (underflow_q & ~clr_err) | (rd_en & empty);
    end

    always_comb begin
        if (FWFT != 0) rdata = empty ? '0 : mem_q[rptr_q];
        else           rdata = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed and random scoreboard bench for sync_fifo_flags (standard and FWFT instances).
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [3:0] wdata = '0;
    logic [3:0] rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
    logic [3:0] f_wdata = '0;
    logic [3:0] f_rdata;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_q[$];
    logic [3:0] rd_exp_q[$];
    logic [3:0] exp_rd = '0;
    bit         m_ovf = 1'b0, m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_flags #(.WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en), .rdata(f_rdata),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the standard instance, then compare against the model.
    task automatic cycle(input bit we, input logic [3:0] wd, input bit re, input bit clr);
        bit full_pre, empty_pre, wacc, racc;
        wr_en = we; wdata = wd; rd_en = re; clr_err = clr;
        full_pre  = (m_q.size() == 8);
        empty_pre = (m_q.size() == 0);
        wacc = we && !full_pre;
        racc = re && !empty_pre;
        if (racc) rd_exp_q.push_back(m_q.pop_front());
        if (wacc) m_q.push_back(wd);
        m_ovf = (m_ovf && !clr) || (we && full_pre);
        m_unf = (m_unf && !clr) || (re && empty_pre);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        if (racc && rd_exp_q.size() > 0) exp_rd = rd_exp_q.pop_front();
        check("rdata", rdata, exp_rd);
        check("count", count, m_q.size());
        check("empty", empty, m_q.size() == 0);
        check("full", full, m_q.size() == 8);
        check("almost_full", almost_full, m_q.size() >= 6);
        check("almost_empty", almost_empty, m_q.size() <= 2);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_rdata", rdata, 0);
        m_q.delete(); rd_exp_q.delete();
        exp_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int writes;
        #2 do_reset();

        // Fill past full, then read back in order.
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b1, 4'(i), 1'b0, 1'b0);
            if (i == 5) check("afull_at5", almost_full, 0);
            if (i == 6) check("afull_at6", almost_full, 1);
            if (i == 7) check("full_at7", full, 0);
            if (i == 8) check("full_at8", full, 1);
            if (i == 9) begin
                check("ovf_count", count, 8);
                check("ovf_flag", overflow, 1);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 4'h0, 1'b1, 1'b0);
            check("fill_rd", rdata, i);
        end
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check("ovf_cleared", overflow, 0);

        // Drain from three and read once more than available.
        cycle(1'b1, 4'hC, 1'b0, 1'b0);
        cycle(1'b1, 4'hD, 1'b0, 1'b0);
        cycle(1'b1, 4'hE, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0); check("drain_rd0", rdata, 4'hC);
        cycle(1'b0, 4'h0, 1'b1, 1'b0); check("drain_rd1", rdata, 4'hD);
        cycle(1'b0, 4'h0, 1'b1, 1'b0); check("drain_rd2", rdata, 4'hE);
        check("drain_empty", empty, 1);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("drain_unf", underflow, 1);
        check("drain_hold", rdata, 4'hE);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check("unf_cleared", underflow, 0);

        // Simultaneous requests at count 4, at empty and at full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 3), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
        check("simul_count", count, 4);
        while (m_q.size() > 0) cycle(1'b0, 4'h0, 1'b1, 1'b0);
        cycle(1'b1, 4'h5, 1'b1, 1'b0);
        check("both_empty_cnt", count, 1);
        check("both_empty_unf", underflow, 1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 4'(i + 8), 1'b0, 1'b1);
        check("full_again", full, 1);
        cycle(1'b1, 4'h9, 1'b1, 1'b0);
        check("both_full_cnt", count, 7);
        check("both_full_ovf", overflow, 1);
        check("both_full_rd", rdata, 4'h5);
        while (m_q.size() > 0) cycle(1'b0, 4'h0, 1'b1, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Random stream exercising pointer wrap.
        writes = 0;
        for (int c = 0; c < 400 && writes < 50; c++) begin
            bit we, re;
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            if (we && m_q.size() < 8) writes++;
            cycle(we, 4'($urandom_range(0, 15)), re, 1'b0);
        end
        for (int c = 0; c < 20 && m_q.size() > 0; c++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("rand_drained", count, 0);

        // Reset mid-stream with five words held.
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0);
        check("pre_rst_count", count, 5);
        do_reset();
        cycle(1'b1, 4'h7, 1'b0, 1'b0);
        cycle(1'b1, 4'h8, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("post_rst_first", rdata, 4'h7);

        // First-word fall-through instance.
        check("fwft_idle_empty", f_empty, 1);
        f_wr_en = 1'b1; f_wdata = 4'hA;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        check("fwft_empty", f_empty, 0);
        check("fwft_head_a", f_rdata, 4'hA);
        f_wr_en = 1'b1; f_wdata = 4'hB;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        check("fwft_still_a", f_rdata, 4'hA);
        check("fwft_count2", f_count, 2);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        check("fwft_head_b", f_rdata, 4'hB);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        check("fwft_drained", f_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
